// File: rtl/ca_period_detector.sv
// Observer for the cellular automaton: keeps a short history of sampled generations,
// counts them, and reports extinction or the length of a detected repeating cycle.
`timescale 1ns/1ps
module ca_period_detector #(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic [N-1:0] lifeState,
    input  logic         clear,
    output logic [15:0]  genCount,
    output logic         periodFound,
    output logic [7:0]   period,
    output logic         dead,
    output logic [1:0]   state
);

    // step is a single-cycle strobe with no backpressure: lifeState is taken on every
    // rising edge where step=1 and clear=0; clear discards a coincident step.

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_TRACKING = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_DEAD     = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     hist_q [DEPTH];
    logic [N-1:0]     hist_d [DEPTH];
    logic [DEPTH-1:0] hist_vld_q, hist_vld_d;
    logic [15:0]      gen_count_q, gen_count_d;
    logic             period_found_q, period_found_d;
    logic [7:0]       period_q, period_d;
    logic             dead_q, dead_d;

    logic             step_acc;
    logic             is_zero;
    logic             match_hit;
    logic [7:0]       match_idx;

    assign step_acc = step & ~clear;
    assign is_zero  = (lifeState == '0);

    // Walk from oldest to newest so the smallest matching index is the one kept.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_vld_q[i] && (hist_q[i] == lifeState)) begin
                match_hit = 1'b1;
                match_idx = 8'(i);
            end
        end
    end

    always_comb begin
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        if (clear) begin
            hist_vld_d = '0;
        end else if (step) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                hist_d[i]     = hist_q[i-1];
                hist_vld_d[i] = hist_vld_q[i-1];
            end
            hist_d[0]     = lifeState;
            hist_vld_d[0] = 1'b1;
        end
    end

    // History data needs no reset: only the valid bits qualify it.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_vld_q <= '0;
        end else begin
            hist_vld_q <= hist_vld_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; extinction outranks a match in the same step.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else if (step) begin
            case (state_q)
                ST_EMPTY:    state_d = is_zero ? ST_DEAD : ST_TRACKING;
                ST_TRACKING: begin
                    if (is_zero) begin
                        state_d = ST_DEAD;
                    end else if (match_hit) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED:   if (is_zero) state_d = ST_DEAD;
                ST_DEAD:     state_d = ST_DEAD;
                default:     state_d = ST_EMPTY;
            endcase
        end
    end

    // Output logic
    always_comb begin
        gen_count_d    = gen_count_q;
        period_found_d = period_found_q;
        period_d       = period_q;
        dead_d         = dead_q;
        if (clear) begin
            gen_count_d    = '0;
            period_found_d = 1'b0;
            period_d       = '0;
            dead_d         = 1'b0;
        end else if (step_acc) begin
            if (gen_count_q != 16'hFFFF) begin
                gen_count_d = gen_count_q + 16'd1;
            end
            if (is_zero) begin
                dead_d = 1'b1;
            end else if ((state_q == ST_TRACKING) && match_hit) begin
                period_found_d = 1'b1;
                period_d       = match_idx + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gen_count_q    <= '0;
            period_found_q <= 1'b0;
            period_q       <= '0;
            dead_q         <= 1'b0;
        end else begin
            gen_count_q    <= gen_count_d;
            period_found_q <= period_found_d;
            period_q       <= period_d;
            dead_q         <= dead_d;
        end
    end

    assign genCount    = gen_count_q;
    assign periodFound = period_found_q;
    assign period      = period_q;
    assign dead        = dead_q;
    assign state       = state_q;

endmodule

// File: doc/ca_period_detector.md
# ca_period_detector

Downstream observer for the cellular automaton array. It samples each new generation of the N-bit life state on a one-cycle `step` strobe and keeps a bounded history of recent generations. From that history it counts generations, flags extinction (all cells dead), and detects when the pattern has entered a repeating cycle, reporting the period. Outputs drive board LEDs / seven-segment logic alongside the raw life state.

## Interface
- `N`, 16, width of the automaton state (must match the automaton array)
- `DEPTH`, 8, number of past generations held in history (1..255)
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `step`  in  1  one-cycle strobe: `lifeState` holds a new generation this cycle
- `lifeState`  in  N  current automaton generation
- `clear`  in  1  synchronous restart of history, counters and flags
- `genCount`  out  16  generations sampled since reset/clear, saturating at 16'hFFFF
- `periodFound`  out  1  sticky: a repeat was detected
- `period`  out  8  cycle length when `periodFound`=1, else 0
- `dead`  out  1  sticky: an all-zero generation was sampled
- `state`  out  2  FSM state: 0 EMPTY, 1 TRACKING, 2 LOCKED, 3 DEAD

## Operation
- History: `DEPTH` entries `hist[0..DEPTH-1]`, each N bits plus a valid bit; `hist[0]` is most recent.
- On accepted `step`: compare `lifeState` against every valid entry in parallel. Match index = smallest i with valid and equal. Then shift history (`hist[i+1]<=hist[i]`, `hist[0]<=lifeState`, valid[0]<=1). The oldest entry drops off.
- `genCount` increments by 1 per accepted step; holds at 16'hFFFF, no wrap.
- FSM:
  - EMPTY: no valid history. step -> TRACKING (or DEAD if `lifeState`==0).
  - TRACKING: step with `lifeState`==0 -> DEAD; else step with match at index i -> LOCKED, `period`<=i+1, `periodFound`<=1; else remain.
  - LOCKED: history and `genCount` keep updating on step; `period` and `periodFound` frozen. Step with `lifeState`==0 -> DEAD.
  - DEAD: `dead`=1. `genCount` keeps counting; history keeps shifting; `period`/`periodFound` unchanged (a dead pattern is not reported as period 1).
- Extinction has priority over match in the same step.
- Period detection only finds cycles of length ≤ `DEPTH`; longer cycles leave the FSM in TRACKING indefinitely (not an error).
- `clear`: all history valid bits <=0, `genCount`<=0, flags<=0, `period`<=0, FSM<=EMPTY. `clear` with `step` in the same cycle: clear wins and the step is discarded.
- Asynchronous reset (`reset`=0) at any time, including mid-history: same values as `clear`, immediately. History data contents are don't-care after reset; only valid bits matter.

## Timing
- All outputs are registered. Effects of a step sampled at edge k are visible after edge k; latency is 1 cycle.
- Back-to-back steps on consecutive cycles are supported. Each one is a distinct generation and is compared against history that already includes the previous step.
- `lifeState` is sampled only when `step`=1. Otherwise it is ignored and may change freely.
- `step` must be synchronous to `clk` and one cycle wide. Upstream provides the synchronization and edge detection of the automaton's button-driven clock.
- Reset values: `genCount`=0, `periodFound`=0, `period`=0, `dead`=0, `state`=0.

## Test plan
- Reset then 3 steps with distinct nonzero states 16'h0001, 16'h0002, 16'h0004 -> `genCount`=3, `state`=1, `periodFound`=0, `period`=0.
- Steps A=16'h00F0, B=16'h0F00, A -> after third step `periodFound`=1, `period`=2, `state`=2. A fourth step B keeps `period`=2 and gives `genCount`=4.
- Step 16'h1234 twice (still life) -> `period`=1 on the second step. Then step 16'h0000 -> `dead`=1, `state`=3, `period` stays 1.
- DEPTH=8: nine distinct states then a repeat of the first -> no match (oldest dropped), `state`=1. Repeat the 2nd state instead -> `period`=8.
- Assert `clear` together with `step` in LOCKED -> next cycle `genCount`=0, all flags 0, `state`=0. A following single step gives `genCount`=1.
- Pulse `reset` low asynchronously between clock edges mid-TRACKING -> outputs go to zero immediately. First step after release sees an empty history (no false match even if equal to pre-reset data). Drive 65 536 steps -> `genCount` saturates at 16'hFFFF.
